// File: rtl/huffman_frame_scheduler.sv
// Frame-level sequencer for a Huffman run-length chunk decoder: resets and primes the
// decoder per frame, forwards display pixel requests, and arbitrates the image RAM port.
module huffman_frame_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  input  logic [ADDR_WIDTH-1:0] image_base,
  input  logic                  host_wr_req,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [31:0]           host_wr_data,
  output logic                  host_wr_ack,
  output logic                  dec_pixel_reset,
  output logic                  dec_pixel_read_next,
  input  logic [ADDR_WIDTH-1:0] dec_RAM_address,
  input  logic [31:0]           dec_color,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write,
  output logic [31:0]           ram_writedata,
  output logic [31:0]           color,
  output logic                  color_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  resync,
  output logic [1:0]            fsm_state
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESET  = 2'd1,
    S_PRIME  = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      pixel_cnt;
  logic [1:0]            prime_cnt;
  logic                  accept;

  // Handshakes: host_wr_req is held stable by the host until host_wr_ack is seen high in
  // the same cycle; the write to RAM happens in exactly that cycle. pixel_req is a
  // single-cycle consume strobe and is never back-pressured: it is either forwarded as
  // dec_pixel_read_next or dropped with an underrun pulse.
  always_comb begin
    state_nx            = state;
    host_wr_ack         = 1'b0;
    ram_write           = 1'b0;
    ram_writedata       = '0;
    ram_address         = base_q + dec_RAM_address;
    dec_pixel_reset     = 1'b0;
    dec_pixel_read_next = 1'b0;
    underrun            = 1'b0;
    resync              = 1'b0;
    accept              = 1'b0;
    case (state)
      S_IDLE: begin
        ram_address = '0;
        underrun    = pixel_req;
        if (frame_start) begin
          state_nx = S_RESET;
        end else if (host_wr_req) begin
          ram_address   = host_wr_addr;
          ram_writedata = host_wr_data;
          ram_write     = 1'b1;
          host_wr_ack   = 1'b1;
        end
      end
      S_RESET: begin
        dec_pixel_reset = 1'b1;
        underrun        = pixel_req;
        state_nx        = S_PRIME;
      end
      S_PRIME: begin
        underrun = pixel_req;
        if (prime_cnt == 2'd2) state_nx = S_ACTIVE;
      end
      S_ACTIVE: begin
        // A restart request takes priority over the pixel arriving with it.
        if (!frame_start) begin
          dec_pixel_read_next = pixel_req;
          accept              = pixel_req;
          if (pixel_req && pixel_cnt == LAST_PIXEL) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (frame_start && state != S_IDLE) begin
      resync   = 1'b1;
      state_nx = S_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      pixel_cnt   <= '0;
      prime_cnt   <= '0;
      color_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      color_valid <= dec_pixel_read_next;
      if (frame_start) base_q <= image_base;
      if (state == S_RESET) prime_cnt <= '0;
      else if (state == S_PRIME) prime_cnt <= prime_cnt + 2'd1;
      if (state == S_PRIME && state_nx == S_ACTIVE) pixel_cnt <= '0;
      else if (accept) pixel_cnt <= pixel_cnt + CNT_W'(1);
    end
  end

  assign color     = dec_color;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_huffman_frame_scheduler.sv
// Directed bench for huffman_frame_scheduler with a RAM model, a stub decoder and a
// colour scoreboard fed from an independently maintained copy of the image memory.
module tb_huffman_frame_scheduler;
  localparam int AW = 16;
  localparam int NP = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RESET = 2'd1, ST_PRIME = 2'd2, ST_ACTIVE = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start, pixel_req;
  logic [AW-1:0] image_base;
  logic          host_wr_req;
  logic [AW-1:0] host_wr_addr;
  logic [31:0]   host_wr_data;
  logic          host_wr_ack;
  logic          dec_pixel_reset, dec_pixel_read_next;
  logic [AW-1:0] dec_addr;
  logic [31:0]   dec_color;
  logic [AW-1:0] ram_address;
  logic          ram_write;
  logic [31:0]   ram_writedata;
  logic [31:0]   color;
  logic          color_valid, busy, underrun, resync;
  logic [1:0]    fsm_state;

  logic [31:0] mem [0:65535];
  logic [31:0] exp_mem [0:65535];
  logic [31:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  huffman_frame_scheduler #(.ADDR_WIDTH(AW), .NUM_PIXELS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_req(pixel_req),
    .image_base(image_base), .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
    .dec_pixel_reset(dec_pixel_reset), .dec_pixel_read_next(dec_pixel_read_next),
    .dec_RAM_address(dec_addr), .dec_color(dec_color), .ram_address(ram_address),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .color(color),
    .color_valid(color_valid), .busy(busy), .underrun(underrun), .resync(resync),
    .fsm_state(fsm_state)
  );

  // RAM plus a stub decoder whose colour register loads the addressed word on read_next.
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_writedata;
    if (!rst_n || dec_pixel_reset) dec_color <= '0;
    else if (dec_pixel_read_next) dec_color <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (color_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("color_valid_unexpected", {31'd0, color_valid}, 32'd0);
      else chk("color", color, exp_q.pop_front());
    end
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    host_wr_req = 1'b1; host_wr_addr = a; host_wr_data = d;
    #1;
    chk("wr_ack", {31'd0, host_wr_ack}, 32'd1);
    chk("wr_ram_write", {31'd0, ram_write}, 32'd1);
    chk("wr_ram_address", {16'd0, ram_address}, {16'd0, a});
    chk("wr_ram_writedata", ram_writedata, d);
    exp_mem[a] = d;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    @(negedge clk);
    frame_start = 1'b1; image_base = base;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pixel(input logic [AW-1:0] a, input logic [AW-1:0] base);
    logic [AW-1:0] ea;
    @(negedge clk);
    pixel_req = 1'b1; dec_addr = a;
    #1;
    ea = base + a;
    chk("px_state", {30'd0, fsm_state}, {30'd0, ST_ACTIVE});
    chk("px_read_next", {31'd0, dec_pixel_read_next}, 32'd1);
    chk("px_ram_address", {16'd0, ram_address}, {16'd0, ea});
    chk("px_host_ack", {31'd0, host_wr_ack}, 32'd0);
    chk("px_ram_write", {31'd0, ram_write}, 32'd0);
    exp_q.push_back(exp_mem[ea]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0; exp_mem[i] = '0;
    end
    rst_n = 1'b0; frame_start = 1'b0; pixel_req = 1'b0; image_base = '0;
    host_wr_req = 1'b0; host_wr_addr = '0; host_wr_data = '0; dec_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_address", {16'd0, ram_address}, 32'd0);
    chk("rst_color_valid", {31'd0, color_valid}, 32'd0);
    chk("rst_ack", {31'd0, host_wr_ack}, 32'd0);
    chk("rst_dec_reset", {31'd0, dec_pixel_reset}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Image upload, including one word near the bottom of memory for the wrap test.
    for (int i = 0; i < 4; i++) host_write(AW'(16'h0100 + i), $urandom);
    host_write(16'h0001, $urandom);

    @(negedge clk);
    host_wr_req = 1'b0; pixel_req = 1'b1;
    #1;
    chk("idle_underrun", {31'd0, underrun}, 32'd1);
    chk("idle_read_next", {31'd0, dec_pixel_read_next}, 32'd0);

    // Frame 1: early requests, then a full 4-pixel frame with a write held mid-frame.
    @(negedge clk);
    pixel_req = 1'b0; frame_start = 1'b1; image_base = 16'h0100;
    #1;
    chk("f1_resync", {31'd0, resync}, 32'd0);
    chk("f1_busy_t0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("f1_state_reset", {30'd0, fsm_state}, {30'd0, ST_RESET});
    chk("f1_dec_reset", {31'd0, dec_pixel_reset}, 32'd1);
    chk("f1_ram_base", {16'd0, ram_address}, 32'h0100);
    chk("f1_busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    pixel_req = 1'b1;
    #1;
    chk("f1_state_prime", {30'd0, fsm_state}, {30'd0, ST_PRIME});
    chk("f1_underrun_t2", {31'd0, underrun}, 32'd1);
    chk("f1_no_rn_t2", {31'd0, dec_pixel_read_next}, 32'd0);
    @(negedge clk);
    pixel_req = 1'b0;
    @(negedge clk);
    pixel_req = 1'b1;
    #1;
    chk("f1_underrun_t4", {31'd0, underrun}, 32'd1);
    chk("f1_no_rn_t4", {31'd0, dec_pixel_read_next}, 32'd0);
    run_pixel(16'd0, 16'h0100);
    run_pixel(16'd1, 16'h0100);
    d = $urandom;
    host_wr_req = 1'b1; host_wr_addr = 16'h0104; host_wr_data = d;
    run_pixel(16'd2, 16'h0100);
    run_pixel(16'd3, 16'h0100);
    chk("f1_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1;
    chk("f1_busy_end", {31'd0, busy}, 32'd0);
    chk("f1_fifth_underrun", {31'd0, underrun}, 32'd1);
    chk("f1_fifth_no_rn", {31'd0, dec_pixel_read_next}, 32'd0);
    chk("f1_held_ack", {31'd0, host_wr_ack}, 32'd1);
    chk("f1_held_addr", {16'd0, ram_address}, 32'h0104);
    exp_mem[16'h0104] = d;
    @(negedge clk);
    pixel_req = 1'b0; host_wr_req = 1'b0;

    // Frame 2: restart at pixel 2 with a base that wraps the address space.
    start_frame(16'h0101);
    run_pixel(16'd0, 16'h0101);
    run_pixel(16'd1, 16'h0101);
    @(negedge clk);
    frame_start = 1'b1; image_base = 16'hFFFE; pixel_req = 1'b1; dec_addr = 16'd2;
    #1;
    chk("rs_resync", {31'd0, resync}, 32'd1);
    chk("rs_no_rn", {31'd0, dec_pixel_read_next}, 32'd0);
    @(negedge clk);
    frame_start = 1'b0; pixel_req = 1'b0; dec_addr = 16'd3;
    #1;
    chk("rs_dec_reset", {31'd0, dec_pixel_reset}, 32'd1);
    chk("rs_wrap_addr", {16'd0, ram_address}, 32'h0001);
    repeat (3) @(negedge clk);
    run_pixel(16'd3, 16'hFFFE);
    run_pixel(16'd4, 16'hFFFE);
    run_pixel(16'd5, 16'hFFFE);
    run_pixel(16'd2, 16'hFFFE);
    @(negedge clk);
    pixel_req = 1'b0;
    #1;
    chk("rs_busy_end", {31'd0, busy}, 32'd0);

    // Arbitration tie: frame wins, the write waits for the frame to end.
    d = $urandom;
    @(negedge clk);
    frame_start = 1'b1; image_base = 16'h0100; dec_addr = 16'd0;
    host_wr_req = 1'b1; host_wr_addr = 16'h0300; host_wr_data = d;
    #1;
    chk("tie_ack", {31'd0, host_wr_ack}, 32'd0);
    chk("tie_ram_write", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("tie_ack_reset", {31'd0, host_wr_ack}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("tie_ack_prime", {31'd0, host_wr_ack}, 32'd0);
      chk("tie_write_prime", {31'd0, ram_write}, 32'd0);
    end
    for (int i = 0; i < NP; i++) run_pixel(AW'(i), 16'h0100);
    @(negedge clk);
    pixel_req = 1'b0;
    #1;
    chk("tie_ack_after", {31'd0, host_wr_ack}, 32'd1);
    chk("tie_addr_after", {16'd0, ram_address}, 32'h0300);
    chk("tie_data_after", ram_writedata, d);
    exp_mem[16'h0300] = d;
    @(negedge clk);
    host_wr_req = 1'b0;

    // Reset in the middle of an active frame.
    start_frame(16'h0100);
    @(negedge clk);
    pixel_req = 1'b1; dec_addr = 16'd0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; pixel_req = 1'b0;
    #1;
    chk("mr_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_color_valid", {31'd0, color_valid}, 32'd0);
    chk("mr_read_next", {31'd0, dec_pixel_read_next}, 32'd0);
    chk("mr_ram_address", {16'd0, ram_address}, 32'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
